sfq_sync_out_checker: RTL and testbench

- Downstream consumer for clocked constant-output cells (always-0 / always-1 sync cells) in cell-characterisation benches.
- Takes toggle-encoded SFQ pulse wires: the cell clock and the cell output q. Any edge on a wire is one pulse.
- Counts q pulses per cell-clock interval over a programmable window and flags intervals whose count differs from the expected value.
- Reports a pass/fail summary in a conventional synchronous clk domain.

---
 rtl/sfq_bench_pkg.sv | 22 ++
 rtl/sfq_tgl_detect.sv | 35 +++
 rtl/sfq_sync_out_checker.sv | 155 +++++++++++++++
 tb/tb_sfq_sync_out_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfq_bench_pkg.sv
// Shared types and helpers for the SFQ cell-characterisation bench logic.
package sfq_bench_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_e;

    // Adds b to a and clamps at lim; callers size lim to their counter width (up to 32 bits).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/sfq_tgl_detect.sv
// Synchronises a toggle-encoded SFQ wire and turns each level change into a one-cycle pulse.
module sfq_tgl_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tgl_i,
    output logic pulse_o
);

    logic level;
    logic prev_q;

    generate
        if (STAGES == 0) begin : g_nosync
            assign level = tgl_i;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;
            // Reset loads the live input level so the first post-reset compare sees no edge.
            always_ff @(posedge clk) begin
                if (rst) sync_q <= {STAGES{tgl_i}};
                else     sync_q <= (sync_q << 1) | STAGES'(tgl_i);
            end
            assign level = sync_q[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) prev_q <= tgl_i;
        else     prev_q <= level;
    end

    assign pulse_o = level ^ prev_q;

endmodule

// File: rtl/sfq_sync_out_checker.sv
// Counts q pulses per cell-clock interval over a window and flags intervals that miss the expected count.
//  state      | meaning
//  ST_IDLE    | after reset, waiting for start
//  ST_ARM     | counters cleared, waiting for the first cell-clock pulse to open interval 0
//  ST_MEASURE | counting q pulses; each cell-clock pulse closes an interval
//  ST_DONE    | results held; start re-arms
module sfq_sync_out_checker
    import sfq_bench_pkg::*;
#(
    parameter int EXP_PER_CLK = 0,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             cell_clk_tgl,
    input  logic             cell_q_tgl,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] q_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               CW1      = CNT_W + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   first_err_q, first_err_d;
    logic [CNT_W-1:0]   iv_idx_q, iv_idx_d;
    logic [1:0]         iv_cnt_q, iv_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               timeout_q, timeout_d;
    logic               clk_pulse, q_pulse;
    logic [1:0]         iv_inc;
    logic               last_iv;

    sfq_tgl_detect #(.STAGES(SYNC_STAGES)) u_det_clk (
        .clk     (clk),
        .rst     (rst),
        .tgl_i   (cell_clk_tgl),
        .pulse_o (clk_pulse)
    );

    sfq_tgl_detect #(.STAGES(SYNC_STAGES)) u_det_q (
        .clk     (clk),
        .rst     (rst),
        .tgl_i   (cell_q_tgl),
        .pulse_o (q_pulse)
    );

    // A q pulse coincident with the cell clock belongs to the interval being closed.
    assign iv_inc  = (q_pulse && iv_cnt_q != 2'd3) ? iv_cnt_q + 2'd1 : iv_cnt_q;
    assign last_iv = (CW1'(iv_idx_q) + CW1'(1)) == CW1'(win_q);

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        q_cnt_d     = q_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        iv_idx_d    = iv_idx_q;
        iv_cnt_d    = iv_cnt_q;
        tmo_d       = tmo_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    win_d       = (win_len == '0) ? CNT_W'(1) : win_len;
                    q_cnt_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = CNT_MAX;
                    iv_idx_d    = '0;
                    iv_cnt_d    = '0;
                    tmo_d       = TMO_LOAD;
                    timeout_d   = 1'b0;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM, ST_MEASURE: begin
                if (clk_pulse) begin
                    tmo_d    = TMO_LOAD;
                    iv_cnt_d = '0;
                    if (state_q == ST_ARM) begin
                        state_d = ST_MEASURE;
                    end else begin
                        if (int'(iv_inc) != EXP_PER_CLK) begin
                            err_cnt_d = CNT_W'(sat_add(32'(err_cnt_q), 32'd1, 32'(CNT_MAX)));
                            if (err_cnt_q == '0) first_err_d = iv_idx_q;
                        end
                        q_cnt_d = CNT_W'(sat_add(32'(q_cnt_q), 32'(iv_inc), 32'(CNT_MAX)));
                        if (last_iv) begin
                            iv_cnt_d = iv_inc;
                            state_d  = ST_DONE;
                        end else begin
                            iv_idx_d = CNT_W'(sat_add(32'(iv_idx_q), 32'd1, 32'(CNT_MAX)));
                        end
                    end
                end else begin
                    if (state_q == ST_MEASURE) iv_cnt_d = iv_inc;
                    if (tmo_q == '0) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= CNT_W'(1);
            q_cnt_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= CNT_MAX;
            iv_idx_q    <= '0;
            iv_cnt_q    <= '0;
            tmo_q       <= TMO_LOAD;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            q_cnt_q     <= q_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            iv_idx_q    <= iv_idx_d;
            iv_cnt_q    <= iv_cnt_d;
            tmo_q       <= tmo_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy          = (state_q == ST_ARM) || (state_q == ST_MEASURE);
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_cnt_q == '0) && !timeout_q;
    assign timeout       = timeout_q;
    assign q_cnt         = q_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_sfq_sync_out_checker.sv
// Drives one pulse stream into an always-0 and an always-1 checker and compares both against an interval-level model.
module tb_sfq_sync_out_checker;

    localparam int TMO  = 32;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst, start, ccl, cq;
    logic [15:0] win_len;
    logic        busy0, done0, pass0, tmo0, busy1, done1, pass1, tmo1;
    logic [15:0] qc0, ec0, fe0, qc1, ec1, fe1;

    int errors = 0;
    int checks = 0;

    // Model: closed interval pulse counts (clamped at 3) for the current measurement.
    int m_iv[$];
    int m_win, m_cur;
    bit m_meas, m_done;

    always #5 clk = ~clk;

    sfq_sync_out_checker #(.EXP_PER_CLK(0), .CNT_W(16), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .cell_clk_tgl(ccl), .cell_q_tgl(cq),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
        .q_cnt(qc0), .err_cnt(ec0), .first_err_idx(fe0)
    );

    sfq_sync_out_checker #(.EXP_PER_CLK(1), .CNT_W(16), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .cell_clk_tgl(ccl), .cell_q_tgl(cq),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
        .q_cnt(qc1), .err_cnt(ec1), .first_err_idx(fe1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_qsum();
        int s = 0;
        foreach (m_iv[i]) s += m_iv[i];
        return s;
    endfunction

    function automatic int m_err(input int exp);
        int e = 0;
        foreach (m_iv[i]) if (m_iv[i] != exp) e++;
        return e;
    endfunction

    function automatic int m_first(input int exp);
        foreach (m_iv[i]) if (m_iv[i] != exp) return i;
        return 32'hFFFF;
    endfunction

    task automatic do_start(input int w);
        start   = 1'b1;
        win_len = w[15:0];
        @(negedge clk);
        start   = 1'b0;
        m_win   = (w == 0) ? 1 : w;
        m_meas  = 0;
        m_cur   = 0;
        m_done  = 0;
        m_iv.delete();
    endtask

    // Toggle the selected wires this cycle, update the model, then idle gap cycles.
    task automatic step(input bit c, input bit q, input int gap);
        if (q) cq = ~cq;
        if (c) ccl = ~ccl;
        if (!m_done) begin
            if (q && m_meas) m_cur++;
            if (c) begin
                if (!m_meas) begin
                    m_meas = 1;
                end else begin
                    m_iv.push_back(m_cur > 3 ? 3 : m_cur);
                    if (m_iv.size() == m_win) m_done = 1;
                end
                m_cur = 0;
            end
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!(done0 && done1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {30'd0, done0, done1}, 32'd3);
    endtask

    task automatic check_all(input string tag, input bit exp_tmo);
        chk({tag, "_done0"}, done0, 1);
        chk({tag, "_tmo0"},  tmo0, exp_tmo);
        chk({tag, "_q0"},    qc0, m_qsum());
        chk({tag, "_err0"},  ec0, m_err(0));
        chk({tag, "_fe0"},   fe0, m_first(0));
        chk({tag, "_pass0"}, pass0, (m_err(0) == 0 && !exp_tmo) ? 1 : 0);
        chk({tag, "_done1"}, done1, 1);
        chk({tag, "_tmo1"},  tmo1, exp_tmo);
        chk({tag, "_q1"},    qc1, m_qsum());
        chk({tag, "_err1"},  ec1, m_err(1));
        chk({tag, "_fe1"},   fe1, m_first(1));
        chk({tag, "_pass1"}, pass1, (m_err(1) == 0 && !exp_tmo) ? 1 : 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, {busy0, busy1}, 0);
        chk({tag, "_done"}, {done0, done1}, 0);
        chk({tag, "_pass"}, {pass0, pass1}, 0);
        chk({tag, "_tmo"},  {tmo0, tmo1}, 0);
        chk({tag, "_q"},    {qc0, qc1}, 0);
        chk({tag, "_err"},  {ec0, ec1}, 0);
        chk({tag, "_fe"},   {fe0, fe1}, 32'hFFFF_FFFF);
    endtask

    initial begin
        int n, w, nq;
        rst = 1'b1; start = 1'b0; ccl = 1'b0; cq = 1'b0; win_len = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean always-0 stream: 9 cell-clock pulses close 8 intervals.
        do_start(8);
        repeat (8) step(1, 0, 4);
        step(1, 0, 0);
        wait_done(n);
        chk("t1_latency", n, SYNC + 1);
        check_all("t1", 0);

        // One stray q pulse inside interval 2.
        do_start(8);
        repeat (3) step(1, 0, 4);
        step(0, 1, 2);
        repeat (5) step(1, 0, 4);
        step(1, 0, 0);
        wait_done(n);
        check_all("t2", 0);

        // q after each clock, plus one coincident with the 2nd clock (belongs to interval 0).
        do_start(4);
        step(1, 0, 5); step(0, 1, 5);
        step(1, 1, 5); step(0, 1, 5);
        step(1, 0, 5); step(0, 1, 5);
        step(1, 0, 5); step(0, 1, 5);
        step(1, 0, 0);
        wait_done(n);
        check_all("t3", 0);

        // win_len 0 acts as 1; start during MEASURE is ignored.
        do_start(0);
        step(1, 0, 4);
        start = 1'b1; win_len = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_busy", {busy0, busy1}, 2'b11);
        chk("t4_notdone", {done0, done1}, 2'b00);
        step(1, 0, 0);
        wait_done(n);
        chk("t4_latency", n, SYNC + 1);
        check_all("t4", 0);

        // Cell clock stalls after two pulses.
        do_start(4);
        step(1, 0, 10);
        step(1, 0, 0);
        wait_done(n);
        chk("t5_tmo_latency", n, TMO + SYNC + 1);
        check_all("t5", 1);

        // Randomised windows and per-interval q counts.
        for (int it = 0; it < 8; it++) begin
            w = $urandom_range(1, 5);
            do_start(w);
            step(1, $urandom_range(0, 1), $urandom_range(2, 3));
            for (int iv = 0; iv < w; iv++) begin
                nq = $urandom_range(0, 4);
                repeat (nq) step(0, 1, $urandom_range(2, 3));
                step(1, $urandom_range(0, 1), (iv == w - 1) ? 0 : $urandom_range(2, 3));
            end
            wait_done(n);
            check_all($sformatf("rnd%0d", it), 0);
        end

        // Reset mid-measurement with both wires held high.
        do_start(8);
        step(1, 0, 4);
        step(0, 1, 3);
        step(1, 0, 4);
        ccl = 1'b1; cq = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        do_start(1);
        repeat (6) @(negedge clk);
        chk("t7_armed", {busy0, done0}, 2'b10);
        step(1, 0, 6);
        chk("t7_open_only", {done0, done1}, 2'b00);
        step(1, 0, 0);
        wait_done(n);
        check_all("t7", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
